// File: rtl/enemy_sprite_engine.sv
// Multi-channel enemy sprite renderer: per-channel life-cycle FSMs, scalable 16x16 masks
// and a two-stage prioritised pixel pipeline producing one registered RGB per clock.
module enemy_sprite_engine #(
  parameter int unsigned NUM_ENEMIES    = 4,
  parameter int unsigned SCALE_LOG2     = 0,
  parameter int unsigned FLASH_FRAMES   = 4,
  parameter int unsigned EXPLODE_FRAMES = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_tick,
  input  logic [9:0]                hcount,
  input  logic [9:0]                vcount,
  input  logic [NUM_ENEMIES-1:0]    spawn,
  input  logic [NUM_ENEMIES-1:0]    hit,
  input  logic [2*NUM_ENEMIES-1:0]  enemy_type,
  input  logic [4*NUM_ENEMIES-1:0]  health,
  input  logic [10*NUM_ENEMIES-1:0] x_mid,
  input  logic [10*NUM_ENEMIES-1:0] y_mid,
  output logic [23:0]               rgb,
  output logic                      pix_hit,
  output logic [2:0]                pix_id,
  output logic [NUM_ENEMIES-1:0]    alive
);

  typedef enum logic [2:0] {StDead, StAlive, StFlash, StExp0, StExp1, StExp2} state_e;

  localparam logic [3:0]        FlashLoad = 4'(FLASH_FRAMES);
  localparam logic [3:0]        ExpLoad   = 4'(EXPLODE_FRAMES);
  localparam logic signed [10:0] Half     = 11'(8 << SCALE_LOG2);

  function automatic logic mask_bit(logic [1:0] t, logic [3:0] r, logic [3:0] c);
    logic [5:0] w;
    logic [5:0] lo;
    if (t == 2'd0) return 1'b1;
    if (t == 2'd1) return (r >= 4'd5 && r <= 4'd10) || (c >= 4'd4 && c <= 4'd11);
    if (r <= 4'd4)       w = 6'd6 + {1'b0, r, 1'b0};
    else if (r <= 4'd9)  w = 6'd16;
    else if (r <= 4'd14) w = 6'd34 - {1'b0, r, 1'b0};
    else                 w = 6'd0;
    lo = 6'd8 - (w >> 1);
    return ({2'b0, c} >= lo) && ({2'b0, c} < lo + w);
  endfunction

  // Returns {covered, colour}; rel is 11-bit signed so sprites never wrap across the screen.
  function automatic logic [24:0] shade(state_e st, logic [1:0] t, logic [3:0] hp,
                                        logic [9:0] h, logic [9:0] v,
                                        logic [9:0] xm, logic [9:0] ym);
    logic signed [10:0] rx, ry, sx, sy, ext;
    logic [10:0]        ox, oy;
    logic               in_box, drawn;
    logic [23:0]        col;
    rx     = $signed({1'b0, h} - {1'b0, xm});
    ry     = $signed({1'b0, v} - {1'b0, ym});
    in_box = (rx >= -Half) && (rx < Half) && (ry >= -Half) && (ry < Half);
    ox     = rx + Half;
    oy     = ry + Half;
    sx     = rx >>> SCALE_LOG2;
    sy     = ry >>> SCALE_LOG2;
    drawn  = 1'b0;
    col    = 24'h0;
    ext    = 11'sd0;
    case (st)
      StAlive, StFlash: begin
        drawn = in_box && mask_bit(t, 4'(oy >> SCALE_LOG2), 4'(ox >> SCALE_LOG2));
        if (st == StFlash)  col = 24'h00FFFF;
        else if (t == 2'd0) col = 24'hFF0000;
        else begin
          case (hp)
            4'd4:    col = 24'hFFFFFF;
            4'd3:    col = 24'hFF00FF;
            4'd2:    col = 24'hFFF000;
            default: col = 24'hFF0000;
          endcase
        end
      end
      StExp0: begin ext = 11'sd8; col = 24'hFF8000; end
      StExp1: begin ext = 11'sd5; col = 24'hFFFF00; end
      StExp2: begin ext = 11'sd2; col = 24'hFF0000; end
      default: ;
    endcase
    if (ext != 11'sd0) drawn = (sx >= -ext) && (sx < ext) && (sy >= -ext) && (sy < ext);
    return {drawn, drawn ? col : 24'h0};
  endfunction

  state_e     state_q [NUM_ENEMIES];
  state_e     state_d [NUM_ENEMIES];
  logic [3:0] cnt_q   [NUM_ENEMIES];
  logic [3:0] cnt_d   [NUM_ENEMIES];

  always_comb begin
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        StDead: if (spawn[i]) state_d[i] = StAlive;
        StAlive, StFlash: begin
          // A hit's counter load takes priority over a coincident frame_tick decrement.
          if (hit[i]) begin
            if (health[4*i +: 4] == 4'd0) begin
              state_d[i] = StExp0;
              cnt_d[i]   = ExpLoad;
            end else begin
              state_d[i] = StFlash;
              cnt_d[i]   = FlashLoad;
            end
          end else if (state_q[i] == StFlash && frame_tick) begin
            cnt_d[i] = cnt_q[i] - 4'd1;
            if (cnt_q[i] <= 4'd1) begin
              state_d[i] = StAlive;
              cnt_d[i]   = 4'd0;
            end
          end
        end
        StExp0, StExp1, StExp2: begin
          if (frame_tick) begin
            cnt_d[i] = cnt_q[i] - 4'd1;
            if (cnt_q[i] <= 4'd1) begin
              cnt_d[i] = ExpLoad;
              if (state_q[i] == StExp0)      state_d[i] = StExp1;
              else if (state_q[i] == StExp1) state_d[i] = StExp2;
              else begin
                state_d[i] = StDead;
                cnt_d[i]   = 4'd0;
              end
            end
          end
        end
        default: begin
          state_d[i] = StDead;
          cnt_d[i]   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        state_q[i] <= StDead;
        cnt_q[i]   <= 4'd0;
        alive[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        alive[i]   <= (state_d[i] == StAlive) || (state_d[i] == StFlash);
      end
    end
  end

  logic        cov_c [NUM_ENEMIES];
  logic [23:0] col_c [NUM_ENEMIES];
  logic        cov_q [NUM_ENEMIES];
  logic [23:0] col_q [NUM_ENEMIES];

  always_comb begin
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      {cov_c[i], col_c[i]} = shade(state_q[i], enemy_type[2*i +: 2], health[4*i +: 4],
                                   hcount, vcount, x_mid[10*i +: 10], y_mid[10*i +: 10]);
    end
  end

  logic [23:0] rgb_d;
  logic        pix_hit_d;
  logic [2:0]  pix_id_d;

  // Walk from highest to lowest index so the lowest covering channel is written last.
  always_comb begin
    rgb_d     = 24'h0;
    pix_hit_d = 1'b0;
    pix_id_d  = 3'd0;
    for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
      if (cov_q[i]) begin
        rgb_d     = col_q[i];
        pix_hit_d = 1'b1;
        pix_id_d  = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        cov_q[i] <= 1'b0;
        col_q[i] <= 24'h0;
      end
      rgb     <= 24'h0;
      pix_hit <= 1'b0;
      pix_id  <= 3'd0;
    end else begin
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        cov_q[i] <= cov_c[i];
        col_q[i] <= col_c[i];
      end
      rgb     <= rgb_d;
      pix_hit <= pix_hit_d;
      pix_id  <= pix_id_d;
    end
  end

endmodule
